// File: rtl/sfr_bus_arbiter_if.sv
// Bus bundle between NUM_M split-transaction masters, the arbiter and the shared SFR slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface sfr_bus_arbiter_if #(
    parameter int NUM_M = 2
);
    logic [NUM_M-1:0]    m_req_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [32*NUM_M-1:0] m_addr_bi;
    logic [4*NUM_M-1:0]  m_be_bi;
    logic [32*NUM_M-1:0] m_wdata_bi;
    logic [NUM_M-1:0]    m_ack_o;
    logic [NUM_M-1:0]    m_resp_o;
    logic [31:0]         m_rdata_bo;

    logic                s_req_o;
    logic                s_we_o;
    logic [31:0]         s_addr_bo;
    logic [31:0]         s_wdata_bo;
    logic [3:0]          s_be_bo;
    logic                s_ack_i;
    logic                s_resp_i;
    logic [31:0]         s_rdata_bi;

    modport slave (
        input  m_req_i, m_we_i, m_addr_bi, m_be_bi, m_wdata_bi,
        input  s_ack_i, s_resp_i, s_rdata_bi,
        output m_ack_o, m_resp_o, m_rdata_bo,
        output s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo
    );

    modport master (
        output m_req_i, m_we_i, m_addr_bi, m_be_bi, m_wdata_bi,
        output s_ack_i, s_resp_i, s_rdata_bi,
        input  m_ack_o, m_resp_o, m_rdata_bo,
        input  s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo
    );
endinterface

// File: rtl/sfr_bus_arbiter.sv
// Round-robin arbiter sharing one SFR slave port among NUM_M masters, one transaction in flight.
// Optional read-response timeout with sticky err_o is enabled by defining SFR_ARB_TIMEOUT_EN.
module sfr_bus_arbiter #(
    parameter int NUM_M       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    sfr_bus_arbiter_if.slave         bus,
    output logic [$clog2(NUM_M)-1:0] grant_bo,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int GW = $clog2(NUM_M);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q;
    logic [GW-1:0]   grant_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic            done;

    if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("sfr_bus_arbiter: unsupported NUM_M or TIMEOUT_CYC");
    end

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_M) sum = sum - NUM_M;
        return sum[GW-1:0];
    endfunction

    // Scan downwards so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (bus.m_req_i[wrap_add(rr_ptr_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_ptr_q, i);
            end
        end
    end

`ifdef SFR_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout_hit;
`endif

    always_comb begin
        state_d        = state_q;
        done           = 1'b0;
        bus.m_ack_o    = '0;
        bus.m_resp_o   = '0;
        bus.m_rdata_bo = '0;
        bus.s_req_o    = 1'b0;
        bus.s_we_o     = 1'b0;
        bus.s_addr_bo  = '0;
        bus.s_wdata_bo = '0;
        bus.s_be_bo    = '0;
`ifdef SFR_ARB_TIMEOUT_EN
        timeout_hit    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = ISSUE;
            end
            ISSUE: begin
                bus.s_req_o            = 1'b1;
                bus.s_we_o             = we_q;
                bus.s_addr_bo          = addr_q;
                bus.s_wdata_bo         = wdata_q;
                bus.s_be_bo            = be_q;
                bus.m_ack_o[grant_q]   = bus.s_ack_i;
                if (bus.s_ack_i) begin
                    if (we_q) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (bus.s_resp_i) begin
                    bus.m_resp_o[grant_q] = 1'b1;
                    bus.m_rdata_bo        = bus.s_rdata_bi;
                    state_d               = IDLE;
                    done                  = 1'b1;
                end
`ifdef SFR_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    bus.m_resp_o[grant_q] = 1'b1;
                    bus.m_rdata_bo        = 32'hDEAD_DEAD;
                    state_d               = IDLE;
                    done                  = 1'b1;
                    timeout_hit           = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured at grant so the slave sees them stable whatever the master does.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                grant_q <= pick_idx;
                we_q    <= bus.m_we_i[pick_idx];
                addr_q  <= bus.m_addr_bi[pick_idx*32 +: 32];
                be_q    <= bus.m_be_bi[pick_idx*4 +: 4];
                wdata_q <= bus.m_wdata_bi[pick_idx*32 +: 32];
            end
            if (done) rr_ptr_q <= wrap_add(grant_q, 1);
        end
    end

`ifdef SFR_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE && state_d == WAIT_RESP) cnt_q <= '0;
            else if (state_q == WAIT_RESP)                cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign grant_bo = grant_q;
    assign busy_o   = (state_q != IDLE);
endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Self-checking bench for sfr_bus_arbiter: vector table, directed corner cases and a
// randomized run scored against a transaction-level round-robin model.
module tb_sfr_bus_arbiter;
    localparam int N = 2;

    typedef struct {
        logic [1:0]  req;
        logic        s_ack;
        logic        s_resp;
        logic [31:0] s_rdata;
        logic        e_sreq;
        logic [1:0]  e_ack;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic        e_grant;
        logic        e_busy;
        logic        chk_bus;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    logic clk;
    logic rst_n;
    logic grant;
    logic busy;
    logic err;
    int   checks   = 0;
    int   failures = 0;

    sfr_bus_arbiter_if #(.NUM_M(N)) bus ();

    sfr_bus_arbiter #(.NUM_M(N), .TIMEOUT_CYC(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus.slave),
        .grant_bo (grant),
        .busy_o   (busy),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic s_ack, input logic s_resp, input logic [31:0] s_rdata);
        bus.m_req_i    = req;
        bus.m_we_i     = we;
        bus.m_addr_bi  = {a1, a0};
        bus.m_wdata_bi = {w1, w0};
        bus.m_be_bi    = 8'hFF;
        bus.s_ack_i    = s_ack;
        bus.s_resp_i   = s_resp;
        bus.s_rdata_bi = s_rdata;
    endtask

    task automatic waitForSReq(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.s_req_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] req, input logic ack, input logic resp,
                                 input logic [31:0] rd, input logic esreq, input logic [1:0] eack,
                                 input logic [1:0] eresp, input logic [31:0] erd, input logic egr,
                                 input logic ebusy, input logic cbus, input logic ewe,
                                 input logic [31:0] eaddr, input logic [31:0] ewd);
        vec_t v;
        v.req = req;       v.s_ack = ack;     v.s_resp = resp;   v.s_rdata = rd;
        v.e_sreq = esreq;  v.e_ack = eack;    v.e_resp = eresp;  v.e_rdata = erd;
        v.e_grant = egr;   v.e_busy = ebusy;  v.chk_bus = cbus;  v.e_we = ewe;
        v.e_addr = eaddr;  v.e_wdata = ewd;
        return v;
    endfunction

    function automatic int pickModel(input logic [1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    vec_t        vecs[11];
    int          left[N];
    int          txn;
    int          cyc;
    bit          ok;
    logic [31:0] t_addr[N];
    logic [31:0] t_wdata[N];
    logic        t_we[N];
    logic [1:0]  req_v;
    logic [1:0]  req_prev;
    logic [1:0]  acked;
    logic        sreq_prev;
    logic        rd_pending;
    logic        resp_driven;
    int          rd_wait;
    int          ptr;
    int          cur;
    int          resp_idx;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",  32'(busy), 0);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_sreq",  32'(bus.s_req_o), 0);
        checkOutput("rst_ack",   32'(bus.m_ack_o), 0);
        checkOutput("rst_resp",  32'(bus.m_resp_o), 0);
        checkOutput("rst_rdata", bus.m_rdata_bo, 0);
        checkOutput("rst_err",   32'(err), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // m0 write 0x14<=0x3, then m1 read 0x00 answered two cycles after ack, then stray slave strobes.
        vecs[0]  = mkv(2'b01, 0, 0, 0,            0, 2'b00, 2'b00, 0,            0, 0, 0, 0, 0,     0);
        vecs[1]  = mkv(2'b01, 0, 0, 0,            1, 2'b00, 2'b00, 0,            0, 1, 1, 1, 32'h14, 32'h3);
        vecs[2]  = mkv(2'b01, 1, 0, 0,            1, 2'b01, 2'b00, 0,            0, 1, 1, 1, 32'h14, 32'h3);
        vecs[3]  = mkv(2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0,            0, 0, 0, 0, 0,     0);
        vecs[4]  = mkv(2'b10, 0, 0, 0,            0, 2'b00, 2'b00, 0,            0, 0, 0, 0, 0,     0);
        vecs[5]  = mkv(2'b10, 1, 0, 0,            1, 2'b10, 2'b00, 0,            1, 1, 1, 0, 32'h0, 32'h0);
        vecs[6]  = mkv(2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0,            1, 1, 0, 0, 0,     0);
        vecs[7]  = mkv(2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 0,            1, 1, 0, 0, 0,     0);
        vecs[8]  = mkv(2'b00, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2'b10, 32'hDEADBEEF, 1, 1, 0, 0, 0,     0);
        vecs[9]  = mkv(2'b00, 0, 1, 32'h12345678, 0, 2'b00, 2'b00, 0,            1, 0, 0, 0, 0,     0);
        vecs[10] = mkv(2'b00, 1, 0, 0,            0, 2'b00, 2'b00, 0,            1, 0, 0, 0, 0,     0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].req, 2'b01, 32'h14, 32'h0, 32'h3, 32'h0,
                          vecs[i].s_ack, vecs[i].s_resp, vecs[i].s_rdata);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_sreq", i),  32'(bus.s_req_o),  32'(vecs[i].e_sreq));
            checkOutput($sformatf("vec%0d_ack", i),   32'(bus.m_ack_o),  32'(vecs[i].e_ack));
            checkOutput($sformatf("vec%0d_resp", i),  32'(bus.m_resp_o), 32'(vecs[i].e_resp));
            checkOutput($sformatf("vec%0d_rdata", i), bus.m_rdata_bo,    vecs[i].e_rdata);
            checkOutput($sformatf("vec%0d_grant", i), 32'(grant),        32'(vecs[i].e_grant));
            checkOutput($sformatf("vec%0d_busy", i),  32'(busy),         32'(vecs[i].e_busy));
            if (vecs[i].chk_bus) begin
                checkOutput($sformatf("vec%0d_we", i),    32'(bus.s_we_o),   32'(vecs[i].e_we));
                checkOutput($sformatf("vec%0d_addr", i),  bus.s_addr_bo,     vecs[i].e_addr);
                checkOutput($sformatf("vec%0d_wdata", i), bus.s_wdata_bo,    vecs[i].e_wdata);
                checkOutput($sformatf("vec%0d_be", i),    32'(bus.s_be_bo),  32'hF);
            end
        end

        // Both masters write four times back to back; grants must strictly alternate from master 0.
        left[0] = 4; left[1] = 4; txn = 0; cyc = 0;
        while ((left[0] > 0 || left[1] > 0) && cyc < 60) begin
            @(posedge clk); #1;
            applyStimulus({1'(left[1] > 0), 1'(left[0] > 0)}, 2'b11, 32'h100, 32'h200,
                          32'hA000 + 32'(4 - left[0]), 32'hB000 + 32'(4 - left[1]), 1'b1, 1'b0, 0);
            @(negedge clk);
            cyc++;
            if (bus.s_req_o) begin
                checkOutput($sformatf("cont%0d_grant", txn), 32'(grant), 32'(txn % 2));
                checkOutput($sformatf("cont%0d_ack", txn), 32'(bus.m_ack_o), 32'(1 << (txn % 2)));
                checkOutput($sformatf("cont%0d_wdata", txn), bus.s_wdata_bo,
                            ((txn % 2) == 0 ? 32'hA000 : 32'hB000) + 32'(txn / 2));
                if (bus.m_ack_o[0]) left[0]--;
                if (bus.m_ack_o[1]) left[1]--;
                txn++;
            end
        end
        checkOutput("cont_txn_count", 32'(txn), 8);

        // Slave stalls ten cycles; master inputs change underneath but the slave side must not.
        @(posedge clk); #1;
        applyStimulus(2'b01, 2'b01, 32'h20, 0, 32'h55AA, 0, 1'b0, 1'b0, 0);
        waitForSReq(ok);
        checkOutput("stall_sreq_seen", 32'(ok), 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            applyStimulus(2'b01, 2'b01, 32'h20 + 32'(c + 1) * 4, 0, 32'h1111 * 32'(c), 0, 1'b0, 1'b0, 0);
            @(negedge clk);
            checkOutput($sformatf("stall%0d_sreq", c),  32'(bus.s_req_o), 1);
            checkOutput($sformatf("stall%0d_addr", c),  bus.s_addr_bo, 32'h20);
            checkOutput($sformatf("stall%0d_wdata", c), bus.s_wdata_bo, 32'h55AA);
            checkOutput($sformatf("stall%0d_ack", c),   32'(bus.m_ack_o), 0);
        end
        @(posedge clk); #1;
        applyStimulus(2'b01, 2'b01, 32'h77, 0, 32'h77, 0, 1'b1, 1'b0, 0);
        @(negedge clk);
        checkOutput("stall_ack", 32'(bus.m_ack_o), 32'h1);
        @(posedge clk); #1;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("stall_idle_busy", 32'(busy), 0);

        // Reset while waiting for a read response aborts silently.
        @(posedge clk); #1;
        applyStimulus(2'b10, 2'b00, 0, 32'h40, 0, 0, 1'b0, 1'b0, 0);
        waitForSReq(ok);
        checkOutput("rstrd_sreq_seen", 32'(ok), 1);
        @(posedge clk); #1;
        applyStimulus(2'b10, 2'b00, 0, 32'h40, 0, 0, 1'b1, 1'b0, 0);
        @(negedge clk);
        checkOutput("rstrd_ack", 32'(bus.m_ack_o), 32'h2);
        @(posedge clk); #1;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("rstrd_wait_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        bus.s_resp_i = 1'b1;
        bus.s_rdata_bi = 32'hCAFE0001;
        #1;
        checkOutput("rstrd_busy",  32'(busy), 0);
        checkOutput("rstrd_sreq",  32'(bus.s_req_o), 0);
        checkOutput("rstrd_resp",  32'(bus.m_resp_o), 0);
        checkOutput("rstrd_grant", 32'(grant), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstrd_late_resp",  32'(bus.m_resp_o), 0);
        checkOutput("rstrd_late_rdata", bus.m_rdata_bo, 0);
        checkOutput("rstrd_late_busy",  32'(busy), 0);
        @(posedge clk); #1;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);

        // Randomized traffic scored against a transaction-level round-robin model.
        ptr = 0; cur = 0; req_v = '0; req_prev = '0; acked = '0; sreq_prev = 1'b0;
        rd_pending = 1'b0; rd_wait = 0;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = 0; t_wdata[i] = 0; t_we[i] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acked[i]) req_v[i] = 1'b0;
                if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    req_v[i]   = 1'b1;
                    t_we[i]    = 1'($urandom_range(0, 1));
                    t_addr[i]  = $urandom & 32'h0000_FFFC;
                    t_wdata[i] = $urandom;
                end
            end
            resp_driven = 1'b0;
            if (rd_pending) begin
                resp_driven = (rd_wait >= 3) || ($urandom_range(0, 1) == 1);
                rd_wait++;
            end
            applyStimulus(req_v, {t_we[1], t_we[0]}, t_addr[0], t_addr[1], t_wdata[0], t_wdata[1],
                          bus.s_req_o && ($urandom_range(0, 2) != 0), resp_driven, $urandom);
            @(negedge clk);
            if (bus.s_req_o && !sreq_prev) begin
                cur = pickModel(req_prev, ptr);
                if (cur < 0) begin
                    checkOutput("rand_spurious_issue", 1, 0);
                    cur = 0;
                end
                checkOutput($sformatf("rand%0d_grant", c), 32'(grant), 32'(cur));
                checkOutput($sformatf("rand%0d_we", c), 32'(bus.s_we_o), 32'(t_we[cur]));
                checkOutput($sformatf("rand%0d_addr", c), bus.s_addr_bo, t_addr[cur]);
                if (t_we[cur]) checkOutput($sformatf("rand%0d_wdata", c), bus.s_wdata_bo, t_wdata[cur]);
            end
            if (rd_pending && resp_driven) begin
                checkOutput($sformatf("rand%0d_resp", c), 32'(bus.m_resp_o), 32'(1 << cur));
                checkOutput($sformatf("rand%0d_rdata", c), bus.m_rdata_bo, bus.s_rdata_bi);
                ptr = (cur + 1) % N;
                rd_pending = 1'b0;
            end else begin
                checkOutput($sformatf("rand%0d_noresp", c), 32'(bus.m_resp_o), 0);
                checkOutput($sformatf("rand%0d_rdata0", c), bus.m_rdata_bo, 0);
            end
            if (bus.s_req_o) begin
                checkOutput($sformatf("rand%0d_ack", c), 32'(bus.m_ack_o),
                            bus.s_ack_i ? 32'(1 << cur) : 32'h0);
                if (bus.s_ack_i) begin
                    if (t_we[cur]) ptr = (cur + 1) % N;
                    else begin
                        rd_pending = 1'b1;
                        rd_wait = 0;
                    end
                end
            end else begin
                checkOutput($sformatf("rand%0d_noack", c), 32'(bus.m_ack_o), 0);
            end
            acked     = bus.m_ack_o;
            sreq_prev = bus.s_req_o;
            req_prev  = req_v;
        end

        #3 rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

`ifdef SFR_ARB_TIMEOUT_EN
        // Silent slave: the arbiter answers on its own after four waiting cycles.
        @(posedge clk); #1;
        applyStimulus(2'b01, 2'b00, 32'h8, 0, 0, 0, 1'b0, 1'b0, 0);
        waitForSReq(ok);
        checkOutput("tmo_sreq_seen", 32'(ok), 1);
        @(posedge clk); #1;
        applyStimulus(2'b01, 2'b00, 32'h8, 0, 0, 0, 1'b1, 1'b0, 0);
        @(negedge clk);
        checkOutput("tmo_ack", 32'(bus.m_ack_o), 32'h1);
        resp_idx = -1; got_rdata = '0; got_resp = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 32'h5555AAAA);
            @(negedge clk);
            if (bus.m_resp_o != 0) begin
                resp_idx  = c;
                got_rdata = bus.m_rdata_bo;
                got_resp  = bus.m_resp_o;
                break;
            end
        end
        checkOutput("tmo_cycle", 32'(resp_idx), 4);
        checkOutput("tmo_resp",  32'(got_resp), 32'h1);
        checkOutput("tmo_rdata", got_rdata, 32'hDEADDEAD);
        @(posedge clk); #1;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 32'h0BADF00D);
        @(negedge clk);
        checkOutput("tmo_late_resp", 32'(bus.m_resp_o), 0);
        checkOutput("tmo_err",       32'(err), 1);
        checkOutput("tmo_busy",      32'(busy), 0);
`else
        @(negedge clk);
        checkOutput("err_tied_low", 32'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
